mux_sel_sequencer: RTL
======================

// Module: mux_sel_sequencer
// PURPOSE
//   Round-robin select generator that drives the select input of the mux2x1 / muxNx1 datapath stage.
//   - Arbitrates among N requesters and grants exactly one at a time.
//   - Holds each grant for at most HOLD cycles, or less if the requester drops.
//   - Presents the winner as a binary select `sel` (steers the mux) plus a one-hot `grant` (tells the source).
// PARAMETERS
//   N     2   number of requesters / mux inputs (N >= 2)
//   HOLD  4   max consecutive cycles per grant (HOLD >= 1)
//   SEL_W $clog2(N)   select width; derived, do not override
// PORTS
//   clk        in   1      single clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   en         in   1      arbitration enable; low forces release to IDLE
//   req        in   N      request vector, bit i = source i wants the mux
//   sel        out  SEL_W  registered mux select
//   sel_valid  out  1      sel refers to a live grant
//   grant      out  N      one-hot copy of sel when sel_valid=1, else 0
// BEHAVIOUR
//   Reset (async, immediate):
//     state=IDLE, sel=0, sel_valid=0, grant=0, cnt=0, last=N-1 (first search starts at 0).
//   Outputs: all registered, no combinational path from req to outputs.
//     First grant appears 1 clk after en=1 and req!=0 are sampled.
//   Pick: first set req bit scanning last+1, last+2, ... wrapping mod N (rr_pick).
//   IDLE:
//     - en=1 and req!=0: go to GRANT; sel=pick, grant=onehot(pick), sel_valid=1, cnt=0.
//     - otherwise stay; sel holds its previous value so the mux output stays steady.
//   GRANT, each cycle, checked in this order:
//     - en=0: -> IDLE next edge; sel_valid=0, grant=0, last=sel, sel held.
//     - release if req[sel]=0 OR cnt=HOLD-1. On release, last<=sel, then:
//         another req pending (rotation from sel+1): switch to it same edge, cnt=0, no bubble;
//         only req[sel] still set (hold expiry): re-grant sel, cnt=0, sel_valid stays 1;
//         req=0: -> IDLE, sel_valid=0, grant=0.
//     - otherwise cnt<=cnt+1, outputs unchanged.
//   cnt width: $clog2(HOLD)+1; never exceeds HOLD-1.
//   HOLD=1: re-arbitrates every cycle.
//   req changes mid-grant on non-selected bits: ignored until the next release.
//   Reset mid-grant: outputs clear without a clock edge. After rst falls, the first grant goes to
//     the lowest set req bit (last=N-1).
//   Invariants: grant is one-hot or zero; grant==0 iff sel_valid==0.
// STRUCTURE
//   Package mux_pkg:
//     typedef enum logic {IDLE, GRANT} msel_state_t;
//     function onehot(idx, N).
//   Sub-module rr_pick: combinational rotating priority encoder.
//     Inputs req[N], last[SEL_W]. Outputs idx[SEL_W], any.
//   Top = FSM + cnt + registered outputs; drives mux2x1 .s from sel.
// TESTING  (N=2, HOLD=4 unless noted; tb ties sel to a mux2x1 with a=1, b=0)
//   1 rst=1, req=2'b11, en=1 -> sel=0, sel_valid=0, grant=00; async assert clears with clk stopped.
//   2 en=1, req=11 steady -> sel_valid rises 1 clk after en; sel=0,0,0,0,1,1,1,1,0...; mux y=1x4,0x4.
//   3 req=01 steady -> sel=0 forever, sel_valid never drops; cnt wraps every 4 cycles.
//   4 req=11, drop req[0] after grant cycle 2 -> sel=1 on the next edge, sel_valid stays 1 (no bubble).
//   5 en 1->0 mid-grant on sel=1 -> next edge sel_valid=0, grant=00, sel stays 1.
//     en 0->1 with req=11 -> sel=0 (rotation from last=1).
//   6 rst pulse mid-grant of sel=1 -> immediate clear; after release with req=10 -> sel=1 one clk later.
//   All runs: assert grant one-hot-or-zero and grant==onehot(sel) whenever sel_valid=1.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin mux select sequencer.
// onehot() is sized for up to MaxN requesters; callers truncate to their own width.
package mux_pkg;

    typedef enum logic {IDLE, GRANT} msel_state_t;

    localparam int unsigned MaxN = 32;

    function automatic logic [MaxN-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MaxN-1:0] v;
        v = '0;
        if (idx < n && idx < MaxN) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req bit searching last+1, last+2, ... wrapping mod N.
// Offset N lands back on last itself, so a lone holder is re-picked after everyone else.
module rr_pick #(
    parameter int unsigned N = 2,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] last_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        logic        found;
        int unsigned j;
        found = 1'b0;
        j     = 0;
        idx_o = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            j = (32'(last_i) + i) % N;
            if (!found && req_i[j]) begin
                found = 1'b1;
                idx_o = SEL_W'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin select generator for a mux datapath stage: grants one requester at a time for at
// most HOLD cycles and presents the winner as a registered binary select plus one-hot grant.
module mux_sel_sequencer
    import mux_pkg::*;
#(
    parameter int unsigned N = 2,
    parameter int unsigned HOLD = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [N-1:0]     req_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             sel_valid_o,
    output logic [N-1:0]     grant_o
);

    localparam int unsigned CntW = $clog2(HOLD) + 1;

    msel_state_t      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [SEL_W-1:0] pick_last;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    // While granted, the search rotates from the current holder; in IDLE from the last holder.
    assign pick_last = (state_q == GRANT) ? sel_q : last_q;

    rr_pick #(
        .N(N)
    ) u_rr_pick (
        .req_i (req_i),
        .last_i(pick_last),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        valid_d = valid_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (en_i && pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
                    grant_d = N'(onehot(32'(pick_idx), N));
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!en_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    grant_d = '0;
                    last_d  = sel_q;
                end else if (!req_i[sel_q] || cnt_q == CntW'(HOLD - 1)) begin
                    last_d = sel_q;
                    cnt_d  = '0;
                    if (pick_any) begin
                        sel_d   = pick_idx;
                        grant_d = N'(onehot(32'(pick_idx), N));
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        grant_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= SEL_W'(N - 1);
            valid_q <= 1'b0;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel_o       = sel_q;
    assign sel_valid_o = valid_q;
    assign grant_o     = grant_q;

endmodule
